fxp_alu_seq: RTL and testbench

FXP_ALU_SEQ -- requirements
Module: fxp_alu_seq

---
 rtl/fxp_alu_seq.sv | 199 +++++++++++++++++++
 tb/tb_fxp_alu_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_alu_seq.sv
// fxp_alu_seq: sequential sign-magnitude fixed-point ALU (add, sub, shift-add mult, restoring div)
// Ports:
//   FXP_ALU_SEQ_CLOCK_50        rising-edge clock
//   FXP_ALU_SEQ_Reset_InLow     synchronous active-low reset
//   FXP_ALU_SEQ_Start_InHigh    request, accepted in IDLE or DONE
//   FXP_ALU_SEQ_Op_BusIn        00 add, 01 sub, 10 mult, 11 div
//   FXP_ALU_SEQ_Aop_BusIn/Bop   operands: MSB sign, N-1 magnitude bits with Q fractional bits
//   FXP_ALU_SEQ_Result_BusOut   registered result, same format
//   FXP_ALU_SEQ_Busy_Out        operation in progress
//   FXP_ALU_SEQ_Done_Out        one-cycle completion pulse
//   FXP_ALU_SEQ_Over_Out        overflow of the last operation
//   FXP_ALU_SEQ_DivZero_Out     divide-by-zero of the last operation
module fxp_alu_seq #(
    parameter int N        = 32,
    parameter int Q        = 15,
    parameter int SATURATE = 1
) (
    input  logic         FXP_ALU_SEQ_CLOCK_50,
    input  logic         FXP_ALU_SEQ_Reset_InLow,
    input  logic         FXP_ALU_SEQ_Start_InHigh,
    input  logic [1:0]   FXP_ALU_SEQ_Op_BusIn,
    input  logic [N-1:0] FXP_ALU_SEQ_Aop_BusIn,
    input  logic [N-1:0] FXP_ALU_SEQ_Bop_BusIn,
    output logic [N-1:0] FXP_ALU_SEQ_Result_BusOut,
    output logic         FXP_ALU_SEQ_Busy_Out,
    output logic         FXP_ALU_SEQ_Done_Out,
    output logic         FXP_ALU_SEQ_Over_Out,
    output logic         FXP_ALU_SEQ_DivZero_Out
);
    localparam int M  = N - 1;
    localparam int QW = M + Q;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [2:0] {IDLE, ADD, MUL, DIV, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, b_q;
    logic           sub_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*M-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [M-1:0]   mplier_q, mplier_d;
    logic [M-1:0]   rem_q, rem_d;
    logic [QW-1:0]  quo_q, quo_d;
    logic [N-1:0]   result_q, result_d;
    logic           over_q, over_d, dz_q, dz_d;

    logic           accept;
    logic [M-1:0]   ma, mb;
    logic           sign_a, sign_b_eff, prod_sign, same_sign, a_ge_b;
    logic [M:0]     add_sum;
    logic [M-1:0]   add_diff, add_mag;
    logic           add_ovf, add_sign;
    logic [2*M-1:0] acc_next;
    logic [M:0]     rem_sh;
    logic           fits;
    logic [M-1:0]   rem_next;
    logic [QW-1:0]  quo_next;
    logic           finish, raw_ovf, raw_sign, raw_dz;
    logic [M-1:0]   raw_mag, fin_mag;

    assign accept = FXP_ALU_SEQ_Start_InHigh && (state_q == IDLE || state_q == DONE);

    assign ma         = a_q[M-1:0];
    assign mb         = b_q[M-1:0];
    assign sign_a     = a_q[N-1];
    assign sign_b_eff = b_q[N-1] ^ sub_q;
    assign prod_sign  = a_q[N-1] ^ b_q[N-1];

    // Sign-magnitude add: equal signs add magnitudes, otherwise subtract the smaller from the larger.
    assign same_sign = sign_a == sign_b_eff;
    assign a_ge_b    = ma >= mb;
    assign add_sum   = {1'b0, ma} + {1'b0, mb};
    assign add_diff  = a_ge_b ? ma - mb : mb - ma;
    assign add_mag   = same_sign ? add_sum[M-1:0] : add_diff;
    assign add_ovf   = same_sign & add_sum[M];
    assign add_sign  = same_sign ? sign_a : (a_ge_b ? sign_a : sign_b_eff);

    // Shift-and-add: multiplicand moves left, multiplier right, one bit per cycle.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Restoring division: quo_q starts as the dividend and fills with quotient bits from the LSB.
    assign rem_sh   = {rem_q, quo_q[QW-1]};
    assign fits     = rem_sh >= {1'b0, mb};
    assign rem_next = fits ? rem_sh[M-1:0] - mb : rem_sh[M-1:0];
    assign quo_next = {quo_q[QW-2:0], fits};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        finish   = 1'b0;
        raw_mag  = '0;
        raw_ovf  = 1'b0;
        raw_sign = 1'b0;
        raw_dz   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d  = FXP_ALU_SEQ_Op_BusIn[1] ? (FXP_ALU_SEQ_Op_BusIn[0] ? DIV : MUL) : ADD;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{M{1'b0}}, FXP_ALU_SEQ_Aop_BusIn[M-1:0]};
                    mplier_d = FXP_ALU_SEQ_Bop_BusIn[M-1:0];
                    rem_d    = '0;
                    quo_d    = {FXP_ALU_SEQ_Aop_BusIn[M-1:0], {Q{1'b0}}};
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                finish   = 1'b1;
                raw_mag  = add_mag;
                raw_ovf  = add_ovf;
                raw_sign = add_sign;
            end
            MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(M - 1)) begin
                    finish   = 1'b1;
                    raw_mag  = acc_next[Q+M-1:Q];
                    raw_ovf  = |acc_next[2*M-1:Q+M];
                    raw_sign = prod_sign;
                end
            end
            DIV: begin
                if (mb == '0) begin
                    finish   = 1'b1;
                    raw_mag  = '1;
                    raw_sign = sign_a;
                    raw_dz   = 1'b1;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(QW - 1)) begin
                        finish   = 1'b1;
                        raw_mag  = quo_next[M-1:0];
                        raw_ovf  = |quo_next[QW-1:M];
                        raw_sign = prod_sign;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (finish) state_d = DONE;
        fin_mag  = (raw_ovf && SATURATE != 0) ? '1 : raw_mag;
        // A zero magnitude never carries a negative sign.
        result_d = finish ? {raw_sign & (|fin_mag), fin_mag} : result_q;
        over_d   = finish ? raw_ovf : over_q;
        dz_d     = finish ? raw_dz : dz_q;
    end

    always_ff @(posedge FXP_ALU_SEQ_CLOCK_50) begin
        if (!FXP_ALU_SEQ_Reset_InLow) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            over_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            over_q   <= over_d;
            dz_q     <= dz_d;
            if (accept) begin
                a_q   <= FXP_ALU_SEQ_Aop_BusIn;
                b_q   <= FXP_ALU_SEQ_Bop_BusIn;
                sub_q <= FXP_ALU_SEQ_Op_BusIn == 2'b01;
            end
        end
    end

    assign FXP_ALU_SEQ_Result_BusOut = result_q;
    assign FXP_ALU_SEQ_Busy_Out      = state_q == ADD || state_q == MUL || state_q == DIV;
    assign FXP_ALU_SEQ_Done_Out      = state_q == DONE;
    assign FXP_ALU_SEQ_Over_Out      = over_q;
    assign FXP_ALU_SEQ_DivZero_Out   = dz_q;
endmodule

// File: tb/tb_fxp_alu_seq.sv
// tb_fxp_alu_seq: scoreboard bench for fxp_alu_seq at N=32, Q=15, SATURATE=1
module tb_fxp_alu_seq;
    localparam int N = 32;

    typedef struct {
        logic [N-1:0] res;
        logic         ovf;
        logic         dz;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] res;
    logic         busy, done, over, dz;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;

    fxp_alu_seq #(.N(N), .Q(15), .SATURATE(1)) dut (
        .FXP_ALU_SEQ_CLOCK_50     (clk),
        .FXP_ALU_SEQ_Reset_InLow  (rst_n),
        .FXP_ALU_SEQ_Start_InHigh (start),
        .FXP_ALU_SEQ_Op_BusIn     (op),
        .FXP_ALU_SEQ_Aop_BusIn    (a),
        .FXP_ALU_SEQ_Bop_BusIn    (b),
        .FXP_ALU_SEQ_Result_BusOut(res),
        .FXP_ALU_SEQ_Busy_Out     (busy),
        .FXP_ALU_SEQ_Done_Out     (done),
        .FXP_ALU_SEQ_Over_Out     (over),
        .FXP_ALU_SEQ_DivZero_Out  (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard: every Done pulse pops one expectation; a Done with nothing pending is an error.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done result=%h at edge %0d", res, edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (res !== e.res || over !== e.ovf || dz !== e.dz || (edge_cnt - e.acc) != e.lat - 1) begin
                    n_fail++;
                    $display("FAIL scoreboard got result=%h over=%b dz=%b lat=%0d, want result=%h over=%b dz=%b lat=%0d",
                             res, over, dz, edge_cnt - e.acc + 1, e.res, e.ovf, e.dz, e.lat);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [N-1:0] r, input logic ov, input logic z, input int lat);
        exp_t e;
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        e = '{r, ov, z, lat, edge_cnt + 1};
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 150 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: %0d results pending, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        op = 2'b10;
        a = 32'h0000C000;
        b = 32'h00010000;
        repeat (3) @(negedge clk);
        n_tests += 5;
        if (res !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", res); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (over !== 1'b0) begin n_fail++; $display("FAIL reset_over got %b want 0", over); end
        if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_divzero got %b want 0", dz); end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        issue(2'b00, 32'h0000C000, 32'h00012000, 32'h0001E000, 1'b0, 1'b0, 2);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy got %b want 1", busy); end
        wait_done("add");
        issue(2'b00, 32'h8000C000, 32'h00012000, 32'h00006000, 1'b0, 1'b0, 2);
        wait_done("add_mixed_sign");
        issue(2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 2);
        wait_done("add_overflow");
    endtask

    task automatic test_sub();
        issue(2'b01, 32'h00008000, 32'h00008000, 32'h00000000, 1'b0, 1'b0, 2);
        wait_done("sub_zero");
        issue(2'b01, 32'h80008000, 32'h80008000, 32'h00000000, 1'b0, 1'b0, 2);
        wait_done("sub_neg_zero");
        issue(2'b01, 32'h80008000, 32'h00008000, 32'h80010000, 1'b0, 1'b0, 2);
        wait_done("sub_neg");
        issue(2'b01, 32'h00008000, 32'h00012000, 32'h8000A000, 1'b0, 1'b0, 2);
        wait_done("sub_cross");
    endtask

    task automatic test_mult();
        issue(2'b10, 32'h0000C000, 32'h80010000, 32'h80018000, 1'b0, 1'b0, 32);
        wait_done("mult");
        issue(2'b10, 32'h80000000, 32'h00010000, 32'h00000000, 1'b0, 1'b0, 32);
        wait_done("mult_zero");
        issue(2'b10, 32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b1, 1'b0, 32);
        wait_done("mult_overflow");
        repeat (3) @(negedge clk);
        n_tests += 2;
        if (over !== 1'b1) begin n_fail++; $display("FAIL over_hold got %b want 1", over); end
        if (res !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL result_hold got %h want 7fffffff", res); end
    endtask

    task automatic test_div();
        issue(2'b11, 32'h00018000, 32'h00010000, 32'h0000C000, 1'b0, 1'b0, 47);
        wait_done("div");
        issue(2'b11, 32'h80018000, 32'h00010000, 32'h8000C000, 1'b0, 1'b0, 47);
        wait_done("div_neg");
        issue(2'b11, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 47);
        wait_done("div_overflow");
        issue(2'b11, 32'h00018000, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 2);
        wait_done("div_zero");
        issue(2'b11, 32'h80010000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 2);
        wait_done("div_zero_neg");
    endtask

    task automatic test_busy_ignore();
        issue(2'b11, 32'h00018000, 32'h00010000, 32'h0000C000, 1'b0, 1'b0, 47);
        repeat (3) @(negedge clk);
        op = 2'b00;
        a = 32'h12345678;
        b = 32'h0000FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got %b want 1", busy); end
        wait_done("busy_ignore");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        op = 2'b00;
        a = 32'h0000C000;
        b = 32'h00012000;
        start = 1'b1;
        e = '{32'h0001E000, 1'b0, 1'b0, 2, edge_cnt + 1};
        sb.push_back(e);
        @(negedge clk);
        op = 2'b01;
        a = 32'h00018000;
        b = 32'h00008000;
        e = '{32'h00010000, 1'b0, 1'b0, 2, edge_cnt + 2};
        sb.push_back(e);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got %b want 1", done); end
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap busy got %b want 1", busy); end
        wait_done("back_to_back");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op = 2'b11;
        a = 32'h00018000;
        b = 32'h00010000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests += 5;
        if (res !== '0) begin n_fail++; $display("FAIL abort_result got %h want 0", res); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        if (over !== 1'b0) begin n_fail++; $display("FAIL abort_over got %b want 0", over); end
        if (dz !== 1'b0) begin n_fail++; $display("FAIL abort_divzero got %b want 0", dz); end
        repeat (60) @(negedge clk);
        issue(2'b00, 32'h00008000, 32'h00008000, 32'h00010000, 1'b0, 1'b0, 2);
        wait_done("after_abort");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at edge %0d, want completion", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mult();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
